cond_unit: RTL and testbench
============================

# cond_unit

Conditional-execution unit for the multicycle ARM core, directly downstream of the instruction decoder. It holds the architectural NZCV flags and evaluates the instruction's condition field against them. It gates the decoder's write requests (PCS, NextPC, RegW, MemW, FlagW) into the actual PCWrite, RegWrite and MemWrite strobes seen by the datapath. A registered condition result carries the pre-update verdict from the execute cycle into the writeback cycle.

## Interface
Parameters:
- CNT_W, 16, width of the squash counter (only meaningful with COND_UNIT_SQUASH_CNT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  ALU result flags {N,Z,C,V}
- FlagW  in  2  flag write request from decoder; [1] = N,Z; [0] = C,V
- PCS  in  1  instruction writes PC (branch or Rd==15)
- NextPC  in  1  unconditional PC+4 update (fetch state)
- RegW  in  1  register-file write request
- MemW  in  1  memory write request
- PCWrite  out  1  PC register enable
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data-memory write enable
- Flags  out  4  current architectural flags {N,Z,C,V}
- CondExR  out  1  registered condition verdict
- squash_cnt  out  CNT_W  saturating count of suppressed writes

## Operation
- CondEx (combinational) is derived from Cond and the current Flags register:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 is treated as 1
- FlagWrite = FlagW & {2{CondEx}}. Uses the unregistered CondEx, so the flags of a failing instruction are never touched.
- Flags[3:2] <= ALUFlags[3:2] when FlagWrite[1]. Flags[1:0] <= ALUFlags[1:0] when FlagWrite[0]. The two halves are independent.
- CondExR <= CondEx on every clock.
- PCWrite = (PCS & CondExR) | NextPC. NextPC is never gated.
- RegWrite = RegW & CondExR.
- MemWrite = MemW & CondExR.
- The unit has no state machine. Sequencing is owned by the decoder FSM, which asserts write requests only in the cycle after the condition is evaluated.

## Timing
- Reset (reset=0, asynchronous): Flags=4'b0000, CondExR=0, squash_cnt=0. PCWrite/RegWrite/MemWrite follow their combinational equations, so after reset only NextPC can assert PCWrite.
- Flag update latency: 1 cycle. New flags are visible on Flags and in CondEx the cycle after FlagWrite.
- Write gating latency: 0 cycles from RegW/MemW/PCS to the outputs, using the CondExR captured at the previous edge.
- Simultaneous FlagW and a write request in the same cycle: the write is gated by the old CondExR, and the flags update at the edge.
- An instruction that sets the flags its own condition depends on (e.g. ADDSEQ) is evaluated against the pre-update flags in both the execute and writeback cycles.
- Reset asserted mid-instruction clears the flags immediately. Any write request in flight is then suppressed, because CondExR=0, unless it is NextPC.

## Configuration
- COND_UNIT_SQUASH_CNT_EN defined: squash_cnt increments by 1 on each clock where (RegW|MemW|PCS) & ~CondExR. It saturates at all-ones and never wraps.
- Not defined: the counter logic is absent and squash_cnt is tied to 0.

## Structure
- Shared package cond_pkg:
  - condition-code localparams (COND_EQ..COND_AL)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - FlagW field indices
- Sub-module cond_check: purely combinational, (Cond, Flags) -> CondEx. It is reusable by a future pipelined variant.
- Top level: flag registers, CondExR flop, output gating, optional counter.

## Test plan
- Reset release, then NextPC=1 with all other requests 0 -> PCWrite=1, RegWrite=0, MemWrite=0, Flags=0000.
- Cond=AL, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100. Then Cond=EQ, RegW=1 one cycle later -> RegWrite=1. With Cond=NE the same sequence gives RegWrite=0.
- Flags=0100, Cond=NE, FlagW=11, ALUFlags=1010 -> Flags stays 0100. The following cycle MemW=1 -> MemWrite=0.
- Partial write: Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100. Then Cond=GE (N=1,V=0) -> CondExR=0 next cycle.
- Sweep all 16 Cond values against all 16 Flags values through CondExR -> matches the equation list above, with Cond=15 always 1.
- With COND_UNIT_SQUASH_CNT_EN and CNT_W=2: five suppressed RegW cycles -> squash_cnt 1,2,3,3,3. Reset mid-count -> 0 immediately.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and FlagW field indices for the conditional-execution unit.
package cond_pkg;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational condition-field evaluation against NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  logic [7:0] base;
  assign {n, z, c, v} = {flags[FLAG_N], flags[FLAG_Z], flags[FLAG_C], flags[FLAG_V]};
  // Odd codes are the complement of the even code below them; AL and 15 are forced true.
  assign base = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
  assign cond_ex = (cond >= COND_AL) | (base[cond[3:1]] ^ cond[0]);
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag state, condition evaluation and write gating for the multicycle core.
// Define COND_UNIT_SQUASH_CNT_EN to count suppressed writes on squash_cnt; otherwise it is tied to 0.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExR,
  output logic [CNT_W-1:0] squash_cnt
);
  logic       cond_ex;
  logic [1:0] flag_write;
  cond_check u_check (.cond(Cond), .flags(Flags), .cond_ex(cond_ex));
  assign flag_write = FlagW & {2{cond_ex}};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Flags   <= 4'b0000;
      CondExR <= 1'b0;
    end else begin
      if (flag_write[FLAGW_NZ]) Flags[3:2] <= ALUFlags[3:2];
      if (flag_write[FLAGW_CV]) Flags[1:0] <= ALUFlags[1:0];
      CondExR <= cond_ex;
    end
  assign PCWrite  = (PCS & CondExR) | NextPC;
  assign RegWrite = RegW & CondExR;
  assign MemWrite = MemW & CondExR;
`ifdef COND_UNIT_SQUASH_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) squash_cnt <= '0;
    else if ((RegW | MemW | PCS) & ~CondExR & ~&squash_cnt) squash_cnt <= squash_cnt + 1'b1;
`else
  assign squash_cnt = '0;
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: randomized and directed checks of cond_unit against a table-driven reference model.
module tb_cond_unit;
  localparam int CW = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] Cond = '0, ALUFlags = '0;
  logic [1:0] FlagW = '0;
  logic PCS = 0, NextPC = 0, RegW = 0, MemW = 0;
  logic PCWrite, RegWrite, MemWrite, CondExR;
  logic [3:0] Flags;
  logic [CW-1:0] squash_cnt;
  int checks = 0, errors = 0;
  logic [3:0] m_flags = '0;
  logic m_cexr = 0;
  int m_cnt = 0;

  cond_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondExR(CondExR), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] expv();
    return {(PCS && m_cexr) || NextPC, RegW && m_cexr, MemW && m_cexr, m_flags, m_cexr};
  endfunction

  function automatic int exp_cnt();
`ifdef COND_UNIT_SQUASH_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                       input logic pcs_i, input logic npc, input logic rw, input logic mw);
    {Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW} = {c, a, fw, pcs_i, npc, rw, mw};
    #3;
  endtask

  task automatic tick();
    logic ce;
    ce = cond_ok(Cond, m_flags);
    if ((RegW || MemW || PCS) && !m_cexr && m_cnt < (1 << CW) - 1) m_cnt++;
    if (FlagW[1] && ce) m_flags[3:2] = ALUFlags[3:2];
    if (FlagW[0] && ce) m_flags[1:0] = ALUFlags[1:0];
    m_cexr = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(4'd14, f, 2'b11, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    #2;
    drive(4'd0, 4'hF, 2'b11, 0, 1, 0, 0);
    checks++;
    if ({PCWrite, RegWrite, MemWrite, Flags, CondExR} !== 8'b1000_0000 || squash_cnt !== '0) begin
      errors++;
      $display("FAIL reset: got pcw=%b rw=%b mw=%b flags=%b cexr=%b cnt=%0d, want 1 0 0 0000 0 0",
               PCWrite, RegWrite, MemWrite, Flags, CondExR, squash_cnt);
    end
    @(posedge clk);
    #1;
    drive(4'd0, 4'h0, 2'b00, 0, 1, 0, 0);
    reset = 1'b1;
    checks++;
    if ({PCWrite, RegWrite, MemWrite, Flags} !== 7'b100_0000) begin
      errors++;
      $display("FAIL after_release: got pcw=%b rw=%b mw=%b flags=%b, want 1 0 0 0000", PCWrite, RegWrite, MemWrite, Flags);
    end
    tick();
  endtask

  task automatic test_eq_ne();
    for (int k = 0; k < 2; k++) begin
      set_flags(4'b0100);
      checks++;
      if (Flags !== 4'b0100) begin
        errors++;
        $display("FAIL flags_set: got %b want 0100", Flags);
      end
      drive(k ? 4'd1 : 4'd0, 4'h0, 2'b00, 0, 0, 0, 0);
      tick();
      drive(4'd14, 4'h0, 2'b00, 0, 0, 1, 0);
      checks++;
      if (RegWrite !== (k == 0)) begin
        errors++;
        $display("FAIL regwrite_%s: got %b want %b", k ? "ne" : "eq", RegWrite, k == 0);
      end
      tick();
    end
  endtask

  task automatic test_failed_flagw();
    set_flags(4'b0100);
    drive(4'd1, 4'b1010, 2'b11, 0, 0, 0, 0);
    tick();
    checks++;
    if (Flags !== 4'b0100) begin
      errors++;
      $display("FAIL failed_flagw: got %b want 0100", Flags);
    end
    drive(4'd14, 4'h0, 2'b00, 0, 0, 0, 1);
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL memwrite_squashed: got %b want 0", MemWrite);
    end
    tick();
  endtask

  task automatic test_partial();
    set_flags(4'b0000);
    drive(4'd14, 4'b1111, 2'b10, 0, 0, 0, 0);
    tick();
    checks++;
    if (Flags !== 4'b1100) begin
      errors++;
      $display("FAIL partial_flags: got %b want 1100", Flags);
    end
    drive(4'd10, 4'h0, 2'b00, 0, 0, 0, 0);
    tick();
    checks++;
    if (CondExR !== 1'b0) begin
      errors++;
      $display("FAIL ge_after_partial: got %b want 0", CondExR);
    end
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++) begin
        set_flags(4'(f));
        drive(4'(c), 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        checks++;
        if (CondExR !== cond_ok(4'(c), 4'(f))) begin
          errors++;
          $display("FAIL sweep cond=%0d flags=%b: got %b want %b", c, f[3:0], CondExR, cond_ok(4'(c), 4'(f)));
        end
      end
  endtask

  task automatic test_squash();
    set_flags(4'b0000);
    drive(4'd0, 4'h0, 2'b00, 0, 0, 0, 0);
    tick();
    m_cnt = 0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_cexr = 0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 4'h0, 2'b00, 0, 0, 1, 0);
      tick();
      checks++;
      if (int'(squash_cnt) !== exp_cnt() || RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL squash step %0d: got cnt=%0d rw=%b want cnt=%0d rw=0", i, squash_cnt, RegWrite, exp_cnt());
      end
    end
    set_flags(4'b1111);
    drive(4'd14, 4'h0, 2'b00, 1, 1, 1, 1);
    reset = 1'b0;
    #1;
    checks++;
    if ({PCWrite, RegWrite, MemWrite, Flags, CondExR} !== 8'b1000_0000 || squash_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: got pcw=%b rw=%b mw=%b flags=%b cexr=%b cnt=%0d, want 1 0 0 0000 0 0",
               PCWrite, RegWrite, MemWrite, Flags, CondExR, squash_cnt);
    end
    reset = 1'b1;
    m_flags = '0;
    m_cexr = 0;
    m_cnt = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom));
      checks++;
      if ({PCWrite, RegWrite, MemWrite, Flags, CondExR} !== expv() || int'(squash_cnt) !== exp_cnt()) begin
        errors++;
        $display("FAIL random %0d: got %b cnt=%0d want %b cnt=%0d", i,
                 {PCWrite, RegWrite, MemWrite, Flags, CondExR}, squash_cnt, expv(), exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_eq_ne();
    test_failed_flagw();
    test_partial();
    test_sweep();
    test_squash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
